// File: rtl/noc_spine_pkg.sv
// Shared definitions for the spine link endpoint: header field geometry and endpoint FSM states.
package noc_spine_pkg;

   localparam int DEST_ADDR_W = 6;
   localparam int GROUP_W     = 4;

   // Header fields are MSB-aligned; offsets count down from flit[DWIDTH-1].
   localparam int DEST_ADDR_MSB_OFS = 0;
   localparam int GROUP_MSB_OFS     = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      HOLD = 2'd2
   } ep_state_t;

endpackage

// File: rtl/spine_sync_fifo.sv
// Pointer/count based synchronous FIFO with a combinational head view.
// A push on a full FIFO is only honoured when a pop happens in the same cycle.
module spine_sync_fifo #(
   parameter int DWIDTH = 16,
   parameter int DEPTH  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              push,
   input  logic [DWIDTH-1:0] push_data,
   input  logic              pop,
   output logic [DWIDTH-1:0] head_data,
   output logic              full,
   output logic              empty
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

   logic [DWIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr_reg;
   logic [AW-1:0]     rd_ptr_reg;
   logic [AW:0]       count_reg;
   logic              do_push;
   logic              do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == FULL_CNT);
   assign do_pop  = pop && !clr && !empty;
   assign do_push = push && !clr && (!full || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (clr) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Storage carries no reset so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   assign head_data = mem[rd_ptr_reg];

endmodule

// File: rtl/spine_link_endpoint.sv
// Spine-switch side of a spineN3 link: misroute filter, overflow-accounted FIFO and re-drive FSM.
// Optional SPINE_LINK_STATS_EN adds fwd_count and peak_occupancy outputs.
module spine_link_endpoint
   import noc_spine_pkg::*;
#(
   parameter int                 DWIDTH       = 16,
   parameter int                 DEPTH        = 8,
   parameter logic [GROUP_W-1:0] SRC_GROUP_ID = 4'b0010
) (
   input  logic                   ACLK,
   input  logic                   ARESETn,
   input  logic [DWIDTH-1:0]      rx_data,
   input  logic                   rx_valid,
   output logic [DWIDTH-1:0]      tx_data,
   output logic                   tx_valid,
   output logic [DEST_ADDR_W-1:0] tx_dest_addr,
   input  logic                   tx_hold,
   input  logic                   flush,
   output logic                   fifo_full,
   output logic                   fifo_empty,
   output logic [7:0]             drop_count,
   output logic [7:0]             misroute_count
`ifdef SPINE_LINK_STATS_EN
   ,
   output logic [15:0]            fwd_count,
   output logic [$clog2(DEPTH):0] peak_occupancy
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;

   ep_state_t          state_reg;
   ep_state_t          state_next;
   logic               pop;
   logic [GROUP_W-1:0] rx_group;
   logic               rx_live;
   logic               rx_misroute;
   logic               rx_accept;
   logic               rx_overflow;
   logic [DWIDTH-1:0]  head_data;
   logic [DWIDTH-1:0]  tx_data_reg;
   logic               tx_valid_reg;
   logic [7:0]         drop_count_reg;
   logic [7:0]         misroute_count_reg;

   // A flit arriving during flush is dropped silently: neither stored nor counted.
   assign rx_group    = rx_data[DWIDTH-1-GROUP_MSB_OFS -: GROUP_W];
   assign rx_live     = rx_valid && !flush;
   assign rx_misroute = rx_live && (rx_group == SRC_GROUP_ID);
   assign rx_accept   = rx_live && !rx_misroute && (!fifo_full || pop);
   assign rx_overflow = rx_live && !rx_misroute && fifo_full && !pop;

   spine_sync_fifo #(
      .DWIDTH (DWIDTH),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk       (ACLK),
      .rst_n     (ARESETn),
      .clr       (flush),
      .push      (rx_accept),
      .push_data (rx_data),
      .pop       (pop),
      .head_data (head_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      state_next = state_reg;
      pop        = 1'b0;
      if (flush) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (!fifo_empty) begin
                  if (!tx_hold) begin
                     pop        = 1'b1;
                     state_next = SEND;
                  end else begin
                     state_next = HOLD;
                  end
               end
            end
            SEND: begin
               if (fifo_empty) begin
                  state_next = IDLE;
               end else if (tx_hold) begin
                  state_next = HOLD;
               end else begin
                  pop = 1'b1;
               end
            end
            HOLD: begin
               if (fifo_empty) begin
                  state_next = IDLE;
               end else if (!tx_hold) begin
                  pop        = 1'b1;
                  state_next = SEND;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // The popped head is captured directly, giving one registered cycle of latency.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_reg    <= IDLE;
         tx_valid_reg <= 1'b0;
         tx_data_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         tx_valid_reg <= pop;
         if (pop) begin
            tx_data_reg <= head_data;
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         drop_count_reg     <= '0;
         misroute_count_reg <= '0;
      end else begin
         if (rx_overflow && (drop_count_reg != 8'hFF)) begin
            drop_count_reg <= drop_count_reg + 8'd1;
         end
         if (rx_misroute && (misroute_count_reg != 8'hFF)) begin
            misroute_count_reg <= misroute_count_reg + 8'd1;
         end
      end
   end

   assign tx_data        = tx_data_reg;
   assign tx_valid       = tx_valid_reg;
   assign tx_dest_addr   = tx_data_reg[DWIDTH-1-DEST_ADDR_MSB_OFS -: DEST_ADDR_W];
   assign drop_count     = drop_count_reg;
   assign misroute_count = misroute_count_reg;

`ifdef SPINE_LINK_STATS_EN
   // Occupancy shadow follows the same push/pop decisions the FIFO acts on.
   logic [CW-1:0] occ_reg;
   logic [CW-1:0] occ_next;
   logic [CW-1:0] peak_reg;
   logic [15:0]   fwd_count_reg;

   always_comb begin
      occ_next = occ_reg;
      if (rx_accept && !pop) begin
         occ_next = occ_reg + CW'(1);
      end else if (pop && !rx_accept) begin
         occ_next = occ_reg - CW'(1);
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         occ_reg       <= '0;
         peak_reg      <= '0;
         fwd_count_reg <= '0;
      end else if (flush) begin
         occ_reg       <= '0;
         peak_reg      <= '0;
         fwd_count_reg <= '0;
      end else begin
         occ_reg <= occ_next;
         if (occ_next > peak_reg) begin
            peak_reg <= occ_next;
         end
         if (pop) begin
            fwd_count_reg <= fwd_count_reg + 16'd1;
         end
      end
   end

   assign fwd_count      = fwd_count_reg;
   assign peak_occupancy = peak_reg;
`endif

endmodule

// File: tb/tb_spine_link_endpoint.sv
// Self-checking bench for spine_link_endpoint: queue-based reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_spine_link_endpoint;

   localparam int DW    = 16;
   localparam int DEPTH = 8;

   logic          ACLK     = 1'b0;
   logic          ARESETn  = 1'b0;
   logic [DW-1:0] rx_data  = '0;
   logic          rx_valid = 1'b0;
   logic          tx_hold  = 1'b0;
   logic          flush    = 1'b0;
   logic [DW-1:0] tx_data;
   logic          tx_valid;
   logic [5:0]    tx_dest_addr;
   logic          fifo_full;
   logic          fifo_empty;
   logic [7:0]    drop_count;
   logic [7:0]    misroute_count;
`ifdef SPINE_LINK_STATS_EN
   logic [15:0]   fwd_count;
   logic [3:0]    peak_occupancy;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   always #5 ACLK = ~ACLK;

   spine_link_endpoint #(
      .DWIDTH       (DW),
      .DEPTH        (DEPTH),
      .SRC_GROUP_ID (4'b0010)
   ) dut (
      .ACLK           (ACLK),
      .ARESETn        (ARESETn),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_dest_addr   (tx_dest_addr),
      .tx_hold        (tx_hold),
      .flush          (flush),
      .fifo_full      (fifo_full),
      .fifo_empty     (fifo_empty),
      .drop_count     (drop_count),
      .misroute_count (misroute_count)
`ifdef SPINE_LINK_STATS_EN
      ,
      .fwd_count      (fwd_count),
      .peak_occupancy (peak_occupancy)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of stored flits and the last launched flit.
   logic [DW-1:0] mq[$];
   logic [DW-1:0] m_tx_data  = '0;
   logic          m_tx_valid = 1'b0;
   int            m_drop     = 0;
   int            m_mis      = 0;

   task automatic model_step();
      if (!ARESETn) begin
         mq.delete();
         m_tx_data  = '0;
         m_tx_valid = 1'b0;
         m_drop     = 0;
         m_mis      = 0;
      end else if (flush) begin
         mq.delete();
         m_tx_valid = 1'b0;
      end else begin
         if (mq.size() > 0 && !tx_hold) begin
            m_tx_data  = mq.pop_front();
            m_tx_valid = 1'b1;
         end else begin
            m_tx_valid = 1'b0;
         end
         if (rx_valid) begin
            if (rx_data[15:12] == 4'b0010) begin
               m_mis = (m_mis < 255) ? m_mis + 1 : 255;
            end else if (mq.size() < DEPTH) begin
               mq.push_back(rx_data);
            end else begin
               m_drop = (m_drop < 255) ? m_drop + 1 : 255;
            end
         end
      end
   endtask

   always @(posedge ACLK or negedge ARESETn) model_step();

   always @(negedge ACLK) begin
      if (chk_en) begin
         chk("tx_valid", 32'(tx_valid), 32'(m_tx_valid));
         chk("tx_data", 32'(tx_data), 32'(m_tx_data));
         chk("tx_dest_addr", 32'(tx_dest_addr), 32'(m_tx_data[15:10]));
         chk("fifo_empty", 32'(fifo_empty), 32'(mq.size() == 0));
         chk("fifo_full", 32'(fifo_full), 32'(mq.size() == DEPTH));
         chk("drop_count", 32'(drop_count), 32'(m_drop));
         chk("misroute_count", 32'(misroute_count), 32'(m_mis));
      end
   end

   task automatic cyc(input logic rv, input logic [DW-1:0] d, input logic h, input logic f);
      rx_valid = rv;
      rx_data  = d;
      tx_hold  = h;
      flush    = f;
      @(posedge ACLK);
      @(negedge ACLK);
   endtask

   initial begin
      logic [3:0] grp;
      @(negedge ACLK);
      @(negedge ACLK);
      ARESETn = 1'b1;
      chk_en  = 1'b1;
      chk("lit_reset_tx_valid", 32'(tx_valid), 32'd0);
      chk("lit_reset_tx_data", 32'(tx_data), 32'd0);
      chk("lit_reset_empty", 32'(fifo_empty), 32'd1);
      chk("lit_reset_full", 32'(fifo_full), 32'd0);
      chk("lit_reset_drop", 32'(drop_count), 32'd0);

      // Single flit, one cycle latency
      cyc(1'b1, 16'h4C21, 1'b0, 1'b0);
      chk("lit_single_pre_valid", 32'(tx_valid), 32'd0);
      cyc(1'b0, 16'h0000, 1'b0, 1'b0);
      chk("lit_single_valid", 32'(tx_valid), 32'd1);
      chk("lit_single_data", 32'(tx_data), 32'h4C21);
      chk("lit_single_dest", 32'(tx_dest_addr), 32'h13);
      cyc(1'b0, 16'h0000, 1'b0, 1'b0);
      chk("lit_single_one_cycle", 32'(tx_valid), 32'd0);
      chk("lit_single_hold_data", 32'(tx_data), 32'h4C21);

      // Burst of 12 under hold: 8 stored, 4 dropped
      for (int i = 0; i < 12; i++) begin
         cyc(1'b1, 16'(16'h4000 + i), 1'b1, 1'b0);
         if (i == 7) chk("lit_burst_full", 32'(fifo_full), 32'd1);
      end
      chk("lit_burst_drop", 32'(drop_count), 32'd4);
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, 16'h0000, 1'b0, 1'b0);
         chk("lit_burst_valid", 32'(tx_valid), 32'd1);
         chk("lit_burst_data", 32'(tx_data), 32'(16'h4000 + i));
      end
      cyc(1'b0, 16'h0000, 1'b0, 1'b0);
      chk("lit_burst_end", 32'(tx_valid), 32'd0);

      // Misroute
      cyc(1'b1, 16'h2800, 1'b0, 1'b0);
      chk("lit_mis_count", 32'(misroute_count), 32'd1);
      chk("lit_mis_empty", 32'(fifo_empty), 32'd1);
      cyc(1'b0, 16'h0000, 1'b0, 1'b0);
      chk("lit_mis_no_tx", 32'(tx_valid), 32'd0);

      // Hold mid-stream
      for (int i = 0; i < 4; i++) cyc(1'b1, 16'(16'h5000 + i), 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) begin
         cyc(1'b0, 16'h0000, 1'b0, 1'b0);
         chk("lit_hold_first", 32'(tx_data), 32'(16'h5000 + i));
      end
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 16'h0000, 1'b1, 1'b0);
         chk("lit_hold_stall", 32'(tx_valid), 32'd0);
      end
      for (int i = 2; i < 4; i++) begin
         cyc(1'b0, 16'h0000, 1'b0, 1'b0);
         chk("lit_hold_rest_valid", 32'(tx_valid), 32'd1);
         chk("lit_hold_rest", 32'(tx_data), 32'(16'h5000 + i));
      end
      cyc(1'b0, 16'h0000, 1'b0, 1'b0);
      chk("lit_hold_empty", 32'(fifo_empty), 32'd1);

      // Full with simultaneous pop
      for (int i = 0; i < 8; i++) cyc(1'b1, 16'(16'h6000 + i), 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) begin
         cyc(1'b1, 16'(16'h6008 + i), 1'b0, 1'b0);
         chk("lit_fullpop_full", 32'(fifo_full), 32'd1);
         chk("lit_fullpop_drop", 32'(drop_count), 32'd4);
         chk("lit_fullpop_data", 32'(tx_data), 32'(16'h6000 + i));
      end
      for (int i = 0; i < 9; i++) cyc(1'b0, 16'h0000, 1'b0, 1'b0);
      chk("lit_fullpop_drained", 32'(fifo_empty), 32'd1);

      // Flush mid-burst
      for (int i = 0; i < 5; i++) cyc(1'b1, 16'(16'h7000 + i), 1'b1, 1'b0);
      cyc(1'b0, 16'h0000, 1'b0, 1'b0);
      cyc(1'b0, 16'h0000, 1'b0, 1'b0);
      cyc(1'b1, 16'h7100, 1'b0, 1'b1);
      chk("lit_flush_empty", 32'(fifo_empty), 32'd1);
      chk("lit_flush_valid", 32'(tx_valid), 32'd0);
      chk("lit_flush_drop", 32'(drop_count), 32'd4);
      chk("lit_flush_mis", 32'(misroute_count), 32'd1);
      chk("lit_flush_data", 32'(tx_data), 32'h7001);
      cyc(1'b0, 16'h0000, 1'b0, 1'b0);
      chk("lit_flush_no_tx", 32'(tx_valid), 32'd0);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         grp = ($urandom_range(0, 9) == 0) ? 4'b0010 : 4'($urandom);
         cyc(1'($urandom_range(0, 99) < 70), {grp, 12'($urandom)},
             1'($urandom_range(0, 99) < 35), 1'($urandom_range(0, 99) < 3));
      end

      // Counter saturation
      cyc(1'b0, 16'h0000, 1'b1, 1'b1);
      for (int i = 0; i < 300; i++) cyc(1'b1, 16'h4123, 1'b1, 1'b0);
      chk("lit_drop_sat", 32'(drop_count), 32'd255);
      for (int i = 0; i < 260; i++) cyc(1'b1, 16'h2ABC, 1'b1, 1'b0);
      chk("lit_mis_sat", 32'(misroute_count), 32'd255);

      // Async reset mid-burst
      cyc(1'b0, 16'h0000, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cyc(1'b1, 16'(16'h4A00 + i), 1'b0, 1'b0);
      rx_valid = 1'b1;
      rx_data  = 16'h4A10;
      @(posedge ACLK);
      #2 ARESETn = 1'b0;
      #1;
      chk("lit_arst_valid", 32'(tx_valid), 32'd0);
      chk("lit_arst_data", 32'(tx_data), 32'd0);
      chk("lit_arst_dest", 32'(tx_dest_addr), 32'd0);
      chk("lit_arst_empty", 32'(fifo_empty), 32'd1);
      chk("lit_arst_full", 32'(fifo_full), 32'd0);
      chk("lit_arst_drop", 32'(drop_count), 32'd0);
      chk("lit_arst_mis", 32'(misroute_count), 32'd0);
      @(negedge ACLK);
      #2 ARESETn = 1'b1;
      cyc(1'b1, 16'h4C21, 1'b0, 1'b0);
      cyc(1'b0, 16'h0000, 1'b0, 1'b0);
      chk("lit_post_rst_data", 32'(tx_data), 32'h4C21);
      cyc(1'b0, 16'h0000, 1'b0, 1'b0);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spine_link_endpoint.md
Name: spine_link_endpoint

Overview:
- Far end of one router spine port: the spine-switch side of a spineN3 link.
- Accepts flits from a tile router's `spineN3_out_data`/`spineN3_out_valid` and buffers them in a FIFO.
- Re-drives buffered flits into a destination group router's `spineN3_in_data`/`in_valid`/`dest_addr` inputs, generating `dest_addr` from the flit header.
- The router spine port has no ready signal, so all flow control, overflow handling and misroute filtering live in this block.

Parameters:
- DWIDTH, 16, flit width; header `dest_addr` is flit[DWIDTH-1:DWIDTH-6].
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- SRC_GROUP_ID, 4'b0010, group ID of the router driving rx; flits addressed back to this group are misroutes.

Ports:
- ACLK  input  1  clock.
- ARESETn  input  1  asynchronous active-low reset.
- rx_data  input  DWIDTH  flit from the router's spine out_data.
- rx_valid  input  1  flit qualifier from the router's spine out_valid.
- tx_data  output  DWIDTH  flit to the destination router's spine in_data.
- tx_valid  output  1  one-cycle qualifier per forwarded flit.
- tx_dest_addr  output  6  equals tx_data[DWIDTH-1:DWIDTH-6].
- tx_hold  input  1  downstream stall; no flit is launched while high.
- flush  input  1  synchronous clear of the FIFO and the state machine.
- fifo_full  output  1  FIFO holds DEPTH entries.
- fifo_empty  output  1  FIFO holds 0 entries.
- drop_count  output  8  saturating count of flits lost to overflow.
- misroute_count  output  8  saturating count of filtered misroutes.

Behaviour:
Reset (ARESETn low, asynchronous):
- tx_data=0, tx_valid=0, tx_dest_addr=0.
- Pointers and count cleared: fifo_empty=1, fifo_full=0.
- drop_count=0, misroute_count=0.
- State machine to IDLE.

Receive path (per rising edge):
- rx_valid high and rx_data[DWIDTH-1:DWIDTH-4] == SRC_GROUP_ID: flit discarded, misroute_count increments (saturates at 255).
- Otherwise, rx_valid high and the FIFO not full: flit written.
- Otherwise, rx_valid high and the FIFO full: flit discarded, drop_count increments (saturates at 255).
- Full is evaluated after the same-cycle read. A full FIFO that launches a flit in the same cycle accepts the incoming write, with no drop.

State machine (IDLE, SEND, HOLD):
- IDLE: tx_valid=0. If not empty and tx_hold=0, pop the head into the tx registers, set tx_valid=1 and go to SEND. If not empty and tx_hold=1, go to HOLD.
- SEND: tx_valid stays high for exactly one cycle per flit.
  - Not empty and tx_hold=0: pop the next flit back-to-back, stay in SEND. Throughput is 1 flit/cycle.
  - Empty: tx_valid=0, go to IDLE.
  - tx_hold=1: tx_valid=0, go to HOLD.
- HOLD: tx_valid=0. When tx_hold=0 and not empty, pop the head, go to SEND. If empty, go to IDLE.

Timing and ordering:
- Latency: a flit written at edge N into an empty FIFO, with tx_hold low, appears with tx_valid at edge N+1, i.e. 1 cycle registered.
- tx_data and tx_dest_addr hold their last value while tx_valid=0.
- Flits leave in arrival order.

Flush:
- Synchronous: clears pointers and count, tx_valid=0, state to IDLE on the next edge.
- Counters are not cleared.
- An rx flit presented in the flush cycle is discarded and not counted.

Simultaneous read and write:
- Count unchanged.
- Write pointer and read pointer each wrap modulo DEPTH.

Optional Feature:
SPINE_LINK_STATS_EN
- Defined: adds output fwd_count [15:0], a wrapping count of flits launched (tx_valid cycles), reset to 0 and cleared by flush.
- Defined: adds output peak_occupancy [$clog2(DEPTH):0], the maximum FIFO count since reset or flush.
- Undefined: neither port exists and no logic is generated.

Decomposition:
- Shared package `noc_spine_pkg` holds:
  - DEST_ADDR_W=6 and GROUP_W=4;
  - header field position localparams;
  - the endpoint state enum (IDLE, SEND, HOLD).
- One natural sub-module: `spine_sync_fifo`.
  - Parameterised DWIDTH/DEPTH, pointer and count based.
  - Provides full, empty, push, pop and head data.
  - The top level holds the filter, the state machine and the counters.

Test Plan:
- Single flit: rx_data=16'h4C21 (dest 6'b010011, group 4'b0100), rx_valid for 1 cycle -> one edge later tx_valid=1 for 1 cycle, tx_data=16'h4C21, tx_dest_addr=6'h13.
- Burst of 12 back-to-back flits 16'h4000..16'h400B, DEPTH=8, tx_hold=1 throughout:
  - fifo_full after 8 flits; drop_count=4.
  - On releasing tx_hold, 8 consecutive tx_valid cycles output 16'h4000..16'h4007 in order.
- Misroute: rx_data=16'h2800 (group 4'b0010 == SRC_GROUP_ID) -> never forwarded, misroute_count=1, fifo_empty stays 1.
- Hold mid-stream: 4 flits queued, tx_hold asserted after the 2nd launch for 3 cycles -> tx_valid low for those 3 cycles; remaining 2 flits follow in order; end in IDLE with fifo_empty=1.
- Full with simultaneous pop: FIFO full in SEND, tx_hold=0, rx_valid=1 -> flit accepted, drop_count unchanged, fifo_full stays 1.
- Async reset mid-burst, and flush mid-burst:
  - ARESETn low for half a cycle -> all outputs 0 immediately.
  - flush=1 -> next edge fifo_empty=1, tx_valid=0, counters retained.
